// File: rtl/placar_pkg.sv
// Shared definitions for the score-keeping stage and the score display.
package placar_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    JOGANDO = 2'b01,
    FIM     = 2'b10
  } estado_t;

  localparam int SCORE_W = 10;
  localparam int COMBO_W = 7;
  localparam int MULT_W  = 3;

  localparam int MAX_PLACAR_DEF = 999;
  localparam int COMBO_STEP_DEF = 10;
  localparam int MAX_MULT_DEF   = 4;
  localparam int COMBO_MAX_DEF  = 127;

  // Digit code the display stage renders as an unlit digit.
  localparam logic [3:0] BLANK_DIGIT = 4'd10;

endpackage

// File: rtl/placar_combo.sv
// Combo counter plus the combinational score multiplier derived from it.
module placar_combo
  import placar_pkg::*;
#(
  parameter int COMBO_STEP = COMBO_STEP_DEF,
  parameter int MAX_MULT   = MAX_MULT_DEF,
  parameter int COMBO_MAX  = COMBO_MAX_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               hit_i,
  input  logic               miss_i,
  output logic [COMBO_W-1:0] combo_o,
  output logic [MULT_W-1:0]  mult_o
);

  logic [COMBO_W-1:0] combo_q, combo_d;
  logic [COMBO_W-1:0] quot_c;
  logic [COMBO_W:0]   mult_full_c;

  // Next combo: clear/miss zero it, a hit counts up and sticks at the ceiling.
  always_comb begin
    combo_d = combo_q;
    if (clear_i || miss_i) begin
      combo_d = '0;
    end else if (hit_i) begin
      if (combo_q != COMBO_W'(COMBO_MAX)) combo_d = combo_q + COMBO_W'(1);
    end
  end

  // Combo register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) combo_q <= '0;
    else         combo_q <= combo_d;
  end

  // Multiplier from the pre-hit combo: 1 + combo/STEP, capped at MAX_MULT.
  always_comb begin
    quot_c      = combo_q / COMBO_W'(COMBO_STEP);
    mult_full_c = {1'b0, quot_c} + (COMBO_W+1)'(1);
    if (mult_full_c > (COMBO_W+1)'(MAX_MULT)) mult_o = MULT_W'(MAX_MULT);
    else                                      mult_o = mult_full_c[MULT_W-1:0];
  end

  assign combo_o = combo_q;

endmodule

// File: rtl/placar.sv
// Score keeper: game FSM, saturating score adder and best-score register.
module placar
  import placar_pkg::*;
#(
  parameter int MAX_PLACAR = MAX_PLACAR_DEF,
  parameter int COMBO_STEP = COMBO_STEP_DEF,
  parameter int MAX_MULT   = MAX_MULT_DEF,
  parameter int COMBO_MAX  = COMBO_MAX_DEF
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               iniciar,
  input  logic               acerto,
  input  logic               erro,
  input  logic               fim_jogo,
  output logic [SCORE_W-1:0] placarAtual,
  output logic [SCORE_W-1:0] placarMaximo,
  output logic [COMBO_W-1:0] combo,
  output logic [1:0]         estado,
  output logic               novo_recorde
);

  estado_t            state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic               rec_q, rec_d;
  logic               clear_c, hit_c, miss_c;
  logic [MULT_W-1:0]  mult;
  logic [SCORE_W:0]   sum_c;

  placar_combo #(
    .COMBO_STEP (COMBO_STEP),
    .MAX_MULT   (MAX_MULT),
    .COMBO_MAX  (COMBO_MAX)
  ) u_combo (
    .clk_i   (CLOCK_50),
    .rst_ni  (reset),
    .clear_i (clear_c),
    .hit_i   (hit_c),
    .miss_i  (miss_c),
    .combo_o (combo),
    .mult_o  (mult)
  );

  // State register.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) state_q <= OCIOSO;
    else        state_q <= state_d;
  end

  // Next state: iniciar always (re)enters JOGANDO, fim_jogo only ends a live game.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OCIOSO:  if (iniciar) state_d = JOGANDO;
      JOGANDO: if (iniciar) state_d = JOGANDO;
               else if (fim_jogo) state_d = FIM;
      FIM:     if (iniciar) state_d = JOGANDO;
      default: state_d = OCIOSO;
    endcase
  end

  // Event strobes with priority iniciar > fim_jogo > erro > acerto.
  always_comb begin
    clear_c = iniciar;
    hit_c   = 1'b0;
    miss_c  = 1'b0;
    if (state_q == JOGANDO && !iniciar && !fim_jogo) begin
      miss_c = erro;
      hit_c  = acerto && !erro;
    end
  end

  // Score, best score and record flag; the sum is one bit wider so it cannot wrap.
  always_comb begin
    sum_c   = {1'b0, score_q} + (SCORE_W+1)'(mult);
    score_d = score_q;
    best_d  = best_q;
    rec_d   = rec_q;
    if (clear_c) begin
      score_d = '0;
      rec_d   = 1'b0;
    end else if (hit_c) begin
      if (sum_c > (SCORE_W+1)'(MAX_PLACAR)) score_d = SCORE_W'(MAX_PLACAR);
      else                                  score_d = sum_c[SCORE_W-1:0];
    end
    // Strictly greater only: a tie with the best score is not a new record.
    if (score_d > best_q) begin
      best_d = score_d;
      rec_d  = 1'b1;
    end
  end

  // Score registers.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      score_q <= '0;
      best_q  <= '0;
      rec_q   <= 1'b0;
    end else begin
      score_q <= score_d;
      best_q  <= best_d;
      rec_q   <= rec_d;
    end
  end

  assign placarAtual  = score_q;
  assign placarMaximo = best_q;
  assign estado       = state_q;
  assign novo_recorde = rec_q;

endmodule

// File: tb/tb_placar.sv
// Directed vector bench for the score keeper.
module tb_placar;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b0;
  logic       iniciar  = 1'b0;
  logic       acerto   = 1'b0;
  logic       erro     = 1'b0;
  logic       fim_jogo = 1'b0;
  logic [9:0] placarAtual, placarMaximo;
  logic [6:0] combo;
  logic [1:0] estado;
  logic       novo_recorde;

  int n_total = 0;
  int n_pass  = 0;

  placar dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .iniciar      (iniciar),
    .acerto       (acerto),
    .erro         (erro),
    .fim_jogo     (fim_jogo),
    .placarAtual  (placarAtual),
    .placarMaximo (placarMaximo),
    .combo        (combo),
    .estado       (estado),
    .novo_recorde (novo_recorde)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic       ini, ac, er, fim;
    int         reps;
    int         atual, maxv, cmb, est, rec;
    string      name;
  } vec_t;

  localparam int NV = 20;
  vec_t vec [NV];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_all(input string name, input int a, input int m, input int c,
                           input int e, input int r);
    chk({name, ".atual"}, int'(placarAtual), a);
    chk({name, ".max"},   int'(placarMaximo), m);
    chk({name, ".combo"}, int'(combo), c);
    chk({name, ".estado"}, int'(estado), e);
    chk({name, ".rec"},   int'(novo_recorde), r);
  endtask

  // One clock with the given event pulses, inputs dropped 1 time unit after the edge.
  task automatic step(input logic i, input logic a, input logic e, input logic f);
    @(negedge CLOCK_50);
    iniciar = i; acerto = a; erro = e; fim_jogo = f;
    @(posedge CLOCK_50);
    #1;
    iniciar = 0; acerto = 0; erro = 0; fim_jogo = 0;
  endtask

  initial begin
    //          ini ac er fim reps atual max cmb est rec
    vec[0]  = '{0, 0, 0, 0,   0,   0,   0,  0, 0, 0, "reset"};
    vec[1]  = '{0, 1, 0, 0,   3,   0,   0,  0, 0, 0, "idle_hits"};
    vec[2]  = '{1, 0, 0, 0,   1,   0,   0,  0, 1, 0, "start1"};
    vec[3]  = '{0, 1, 0, 0,  25,  45,  45, 25, 1, 1, "hits25"};
    vec[4]  = '{0, 0, 0, 1,   1,  45,  45, 25, 2, 1, "end1"};
    vec[5]  = '{0, 1, 0, 0,   1,  45,  45, 25, 2, 1, "fim_hit"};
    vec[6]  = '{0, 0, 1, 1,   1,  45,  45, 25, 2, 1, "fim_miss_end"};
    vec[7]  = '{1, 0, 0, 0,   1,   0,  45,  0, 1, 0, "start2"};
    vec[8]  = '{0, 1, 0, 0,  12,  14,  45, 12, 1, 0, "hits12"};
    vec[9]  = '{0, 1, 1, 0,   1,  14,  45,  0, 1, 0, "hit_and_miss"};
    vec[10] = '{0, 1, 0, 0,   1,  15,  45,  1, 1, 0, "hit_after_miss"};
    vec[11] = '{0, 1, 0, 0,  12,  30,  45, 13, 1, 0, "reach30"};
    vec[12] = '{0, 1, 0, 1,   1,  30,  45, 13, 2, 0, "end_with_hit"};
    vec[13] = '{1, 0, 0, 0,   1,   0,  45,  0, 1, 0, "start3"};
    vec[14] = '{0, 1, 0, 0,  25,  45,  45, 25, 1, 0, "tie45"};
    vec[15] = '{0, 0, 1, 0,   1,  45,  45,  0, 1, 0, "miss"};
    vec[16] = '{0, 1, 0, 0,   1,  46,  46,  1, 1, 1, "beat46"};
    vec[17] = '{1, 1, 0, 1,   1,   0,  46,  0, 1, 0, "restart_prio"};
    vec[18] = '{0, 1, 0, 0, 300, 999, 999,127, 1, 1, "saturate"};
    vec[19] = '{0, 0, 1, 0,   1, 999, 999,  0, 1, 1, "sat_miss"};

    reset = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #2 reset = 1'b1;

    for (int k = 0; k < NV; k++) begin
      for (int r = 0; r < vec[k].reps; r++) step(vec[k].ini, vec[k].ac, vec[k].er, vec[k].fim);
      check_all(vec[k].name, vec[k].atual, vec[k].maxv, vec[k].cmb, vec[k].est, vec[k].rec);
    end

    // Build up score 120 in a fresh game: 10x1 + 10x2 + 10x3 + 15x4.
    step(1, 0, 0, 0);
    for (int r = 0; r < 45; r++) step(0, 1, 0, 0);
    check_all("pre_reset", 120, 999, 45, 1, 0);

    // Asynchronous reset mid-cycle: outputs must clear before the next edge.
    @(posedge CLOCK_50);
    #3 reset = 1'b0;
    #1 check_all("async_reset", 0, 0, 0, 0, 0);
    #2 reset = 1'b1;

    // After release, hits in OCIOSO do nothing until iniciar.
    for (int r = 0; r < 3; r++) step(0, 1, 0, 0);
    check_all("post_reset_idle", 0, 0, 0, 0, 0);
    step(1, 0, 0, 0);
    check_all("post_reset_start", 0, 0, 0, 1, 0);
    step(0, 1, 0, 0);
    check_all("post_reset_hit", 1, 1, 1, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/placar.md
Name: placar

Overview:
- Score-keeping stage directly upstream of the seven-segment score display.
- Consumes single-cycle hit/miss/start/end events from the game logic and maintains the current score, best score and combo.
- Presents current and best score as registered 10-bit binary values in the display's input format.
- Range 0..999, so the display never needs more than three digits per score.

Parameters:
- MAX_PLACAR, 999: saturation ceiling for both scores; must be ≤ 1023.
- COMBO_STEP, 10: consecutive hits per multiplier step.
- MAX_MULT, 4: multiplier ceiling.
- COMBO_MAX, 127: combo counter saturation value.

Ports:
- CLOCK_50  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- iniciar  in  1  one-cycle pulse that starts or restarts a game.
- acerto  in  1  one-cycle pulse for a note hit.
- erro  in  1  one-cycle pulse for a note miss.
- fim_jogo  in  1  one-cycle pulse that ends the game.
- placarAtual  out  10  current game score, binary 0..MAX_PLACAR.
- placarMaximo  out  10  best score since reset, binary 0..MAX_PLACAR.
- combo  out  7  consecutive hits in the current game.
- estado  out  2  00 OCIOSO, 01 JOGANDO, 10 FIM.
- novo_recorde  out  1  high while the current game's score is the best score and is > 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - estado=OCIOSO.
  - placarAtual, placarMaximo, combo and novo_recorde all 0.
  - Takes effect immediately, including mid-game. No persistence of placarMaximo across reset.
- All outputs are registered. An event sampled at edge N is visible after edge N, i.e. 1-cycle latency.
- State machine:
  - OCIOSO: iniciar -> JOGANDO, clears placarAtual, combo and novo_recorde. acerto/erro/fim_jogo are ignored.
  - JOGANDO:
    - fim_jogo -> FIM.
    - iniciar -> stays in JOGANDO and clears placarAtual, combo and novo_recorde (restart). placarMaximo is kept.
  - FIM:
    - All scores are frozen; acerto, erro and fim_jogo are ignored.
    - iniciar -> JOGANDO with the same clearing as above.
- Event priority within one cycle: iniciar > fim_jogo > erro > acerto.
  - fim_jogo with acerto in the same cycle: the hit is discarded.
  - acerto with erro in the same cycle: treated as a miss.
- Miss (JOGANDO): combo <= 0. placarAtual is unchanged.
- Hit (JOGANDO):
  - mult = min(1 + combo/COMBO_STEP, MAX_MULT), using the combo value before this hit. Integer division, unsigned.
  - placarAtual <= min(placarAtual + mult, MAX_PLACAR). Compute the sum at 11 bits so it cannot wrap.
  - combo <= min(combo + 1, COMBO_MAX).
- Best score:
  - On the same edge that placarAtual takes next value P: if P > placarMaximo, then placarMaximo <= P and novo_recorde <= 1.
  - A tie does not set novo_recorde.
  - novo_recorde stays 1 for the rest of the game, including FIM, and clears on iniciar or reset.
- At saturation (placarAtual = MAX_PLACAR): further hits still advance combo; the score and the best score stay at MAX_PLACAR.

Decomposition:
- Shared package:
  - State encodings OCIOSO/JOGANDO/FIM.
  - Score width 10 and combo width 7.
  - Default MAX_PLACAR, COMBO_STEP, MAX_MULT, COMBO_MAX.
  - Blank-digit code 10, shared with the display stage.
- Sub-module placar_combo:
  - Contains the combo counter and the combinational multiplier.
  - Inputs: clock, reset, clear, hit, miss.
  - Outputs: combo and mult.
- The top level holds the FSM, the score adder/saturation and the best-score register.

Test Plan:
- Reset, then in OCIOSO pulse acerto ×3 -> placarAtual=0, combo=0, estado=00. Pulse iniciar -> estado=01.
- iniciar, then 25 acerto pulses -> combo=25, placarAtual=10×1+10×2+5×3=45, placarMaximo=45, novo_recorde=1.
- Mid-combo (combo=12), acerto and erro in the same cycle -> combo=0, placarAtual unchanged. Next acerto adds 1.
- Game 1 ends at 45 via fim_jogo. Then acerto -> no change. Then iniciar, reach 30, fim_jogo -> placarAtual=30, placarMaximo=45, novo_recorde=0. Then iniciar, reach 45 -> novo_recorde=0. One more hit -> 46/46, novo_recorde=1.
- Force a long game: 300 hits -> placarAtual saturates at 999, combo saturates at 127, placarMaximo=999, no wrap.
- Assert reset low asynchronously mid-clock during JOGANDO with score 120 -> all outputs 0 and estado=00 before the next edge. Release reset -> state holds until iniciar.
